// File: rtl/swap_pkg.sv
// swap_pkg
// Shared definitions for the swap/copy memory engine:
//   - cmd_op encodings (NOP, SWAP, COPY, reserved)
//   - FSM state type used by swap_mem_engine
// No ports; imported by the engine.
package swap_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_SWAP = 2'b01;
    localparam logic [1:0] OP_COPY = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR_A = 3'd2,
        ST_WR_B = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

endpackage

// File: rtl/swap_mem_engine_if.sv
// swap_mem_engine_if
// Bundles the host write port, host read port and command/status signals
// of the swap/copy memory engine.
//   master : host side (drives we/addr_w/data_w, addr_r, cmd_*)
//   slave  : engine side (drives wr_ready, data_r, cmd_ready, busy, done, err)
interface swap_mem_engine_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr_w;
    logic [DATA_WIDTH-1:0] data_w;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_addr_a;
    logic [ADDR_WIDTH-1:0] cmd_addr_b;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output we, addr_w, data_w, addr_r,
        output cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b,
        input  wr_ready, data_r, cmd_ready, busy, done, err
    );

    modport slave (
        input  we, addr_w, data_w, addr_r,
        input  cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b,
        output wr_ready, data_r, cmd_ready, busy, done, err
    );

endinterface

// File: rtl/swap_reg_array.sv
// swap_reg_array
// DEPTH-word register file with one synchronous write port, two
// asynchronous read ports and an asynchronous clear of every word.
//   clk, reset_n        : clock, async active-low clear
//   we, addr_w, data_w  : write port (out-of-range addresses ignored)
//   addr_0 / data_0     : read port 0 (0 when out of range)
//   addr_1 / data_1     : read port 1 (0 when out of range)
module swap_reg_array #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr_w,
    input  logic [DATA_WIDTH-1:0] data_w,
    input  logic [ADDR_WIDTH-1:0] addr_0,
    output logic [DATA_WIDTH-1:0] data_0,
    input  logic [ADDR_WIDTH-1:0] addr_1,
    output logic [DATA_WIDTH-1:0] data_1
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (32'(addr_w) < DEPTH)) begin
            mem[addr_w] <= data_w;
        end
    end

    assign data_0 = (32'(addr_0) < DEPTH) ? mem[addr_0] : '0;
    assign data_1 = (32'(addr_1) < DEPTH) ? mem[addr_1] : '0;

endmodule

// File: rtl/swap_mem_engine.sv
// swap_mem_engine
// Host-writable register memory with a command engine that swaps two words
// or copies word A to word B.
//   clk      : clock, all state on rising edge
//   reset_n  : async active-low reset (state IDLE, memory and temps cleared)
//   bus      : swap_mem_engine_if.slave -- host write/read ports, command
//              handshake (cmd_valid/cmd_ready/cmd_op/cmd_addr_a/cmd_addr_b)
//              and status (busy, done, err)
// Build option: define SWAP_COPY_EN to enable the COPY op; otherwise op 10
// is rejected like the reserved op.
module swap_mem_engine
    import swap_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    swap_mem_engine_if.slave bus
);

    state_t                state;
    state_t                state_next;
    logic [1:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_a_q;
    logic [ADDR_WIDTH-1:0] addr_b_q;
    logic [DATA_WIDTH-1:0] tmp_a;
    logic [DATA_WIDTH-1:0] tmp_b;

    logic                  op_legal;
    logic                  cmd_legal;
    logic                  idle;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr_w;
    logic [DATA_WIDTH-1:0] mem_data_w;
    logic [ADDR_WIDTH-1:0] fsm_rd_addr;
    logic [DATA_WIDTH-1:0] fsm_rd_data;

    // Read port 0 serves the host; read port 1 belongs to the FSM.
    swap_reg_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (mem_we),
        .addr_w  (mem_addr_w),
        .data_w  (mem_data_w),
        .addr_0  (bus.addr_r),
        .data_0  (bus.data_r),
        .addr_1  (fsm_rd_addr),
        .data_1  (fsm_rd_data)
    );

    // Command legality: both addresses implemented and a supported op.
    always_comb begin
`ifdef SWAP_COPY_EN
        op_legal = (bus.cmd_op != OP_RSVD);
`else
        op_legal = (bus.cmd_op == OP_NOP) || (bus.cmd_op == OP_SWAP);
`endif
        cmd_legal = op_legal
                 && (32'(bus.cmd_addr_a) < DEPTH)
                 && (32'(bus.cmd_addr_b) < DEPTH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    if (!cmd_legal)               state_next = ST_ERR;
                    else if (bus.cmd_op == OP_NOP) state_next = ST_DONE;
                    else                          state_next = ST_RD;
                end
            end
`ifdef SWAP_COPY_EN
            ST_RD:   state_next = (op_q == OP_SWAP) ? ST_WR_A : ST_WR_B;
`else
            ST_RD:   state_next = ST_WR_A;
`endif
            ST_WR_A: state_next = ST_WR_B;
            ST_WR_B: state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            ST_ERR:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // With only one FSM read port, a SWAP reads B in RD and A in WR_A.
    // Host writes are blocked while busy, so the value of A seen in WR_A
    // (before that edge's write lands) is the same as in RD.
    always_comb begin
        idle        = (state == ST_IDLE);
        mem_we      = idle && bus.we && (32'(bus.addr_w) < DEPTH);
        mem_addr_w  = bus.addr_w;
        mem_data_w  = bus.data_w;
        fsm_rd_addr = addr_a_q;
        case (state)
            ST_RD: begin
                fsm_rd_addr = (op_q == OP_SWAP) ? addr_b_q : addr_a_q;
            end
            ST_WR_A: begin
                mem_we     = 1'b1;
                mem_addr_w = addr_a_q;
                mem_data_w = tmp_b;
            end
            ST_WR_B: begin
                mem_we     = 1'b1;
                mem_addr_w = addr_b_q;
                mem_data_w = tmp_a;
            end
            default: ;
        endcase
        bus.wr_ready  = idle;
        bus.cmd_ready = idle;
        bus.busy      = !idle;
        bus.done      = (state == ST_DONE);
        bus.err       = (state == ST_ERR);
    end

    // Command latching and operand temporaries.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= OP_NOP;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tmp_a    <= '0;
            tmp_b    <= '0;
        end else begin
            if (idle && bus.cmd_valid) begin
                op_q     <= bus.cmd_op;
                addr_a_q <= bus.cmd_addr_a;
                addr_b_q <= bus.cmd_addr_b;
            end
            if (state == ST_RD) begin
                if (op_q == OP_SWAP) tmp_b <= fsm_rd_data;
                else                 tmp_a <= fsm_rd_data;
            end
            if (state == ST_WR_A) begin
                tmp_a <= fsm_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_swap_mem_engine.sv
// tb_swap_mem_engine
// Directed bench for swap_mem_engine with DEPTH=100, ADDR_WIDTH=7,
// DATA_WIDTH=8. Expectations are hand-computed constants; COPY expectations
// depend on whether SWAP_COPY_EN is defined.
module tb_swap_mem_engine;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    swap_mem_engine_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) bus_if ();

    swap_mem_engine #(
        .ADDR_WIDTH (7),
        .DATA_WIDTH (8),
        .DEPTH      (100)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic valid, input logic [1:0] op,
                                  input logic [6:0] a, input logic [6:0] b);
        bus_if.cmd_valid  = valid;
        bus_if.cmd_op     = op;
        bus_if.cmd_addr_a = a;
        bus_if.cmd_addr_b = b;
    endtask

    task automatic host_write(input logic [6:0] a, input logic [7:0] d);
        bus_if.we     = 1'b1;
        bus_if.addr_w = a;
        bus_if.data_w = d;
        tick();
        bus_if.we     = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [6:0] a, input logic [7:0] exp);
        bus_if.addr_r = a;
        #1;
        check_output(tag, 32'(bus_if.data_r), 32'(exp));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        bus_if.we = 1'b0;
        bus_if.addr_w = '0;
        bus_if.data_w = '0;
        bus_if.addr_r = 7'd20;
        apply_stimulus(1'b0, 2'b00, 7'd0, 7'd0);

        // Reset state
        #12;
        check_output("rst_busy",      32'(bus_if.busy),      32'd0);
        check_output("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
        check_output("rst_wr_ready",  32'(bus_if.wr_ready),  32'd1);
        check_output("rst_done",      32'(bus_if.done),      32'd0);
        check_output("rst_err",       32'(bus_if.err),       32'd0);
        check_output("rst_data_r",    32'(bus_if.data_r),    32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Fill 20..29 with data = address and read back
        for (int i = 20; i < 30; i++) host_write(7'(i), 8'(i));
        for (int i = 20; i < 30; i++) read_check("fill_rd", 7'(i), 8'(i));

        // Boundary host writes: top word kept, out-of-range dropped/reads 0
        host_write(7'd99, 8'h99);
        read_check("wr_top", 7'd99, 8'h99);
        host_write(7'd110, 8'h55);
        read_check("wr_oor", 7'd110, 8'h00);

        // SWAP 22/28 with a host write to 24 attempted while busy
        apply_stimulus(1'b1, 2'b01, 7'd22, 7'd28);
        check_output("swap_ready", 32'(bus_if.cmd_ready), 32'd1);
        tick();
        apply_stimulus(1'b0, 2'b00, 7'd0, 7'd0);
        bus_if.we = 1'b1;
        bus_if.addr_w = 7'd24;
        bus_if.data_w = 8'hAA;
        check_output("swap_c1_busy",     32'(bus_if.busy),     32'd1);
        check_output("swap_c1_wr_ready", 32'(bus_if.wr_ready), 32'd0);
        check_output("swap_c1_done",     32'(bus_if.done),     32'd0);
        tick();
        check_output("swap_c2_done", 32'(bus_if.done), 32'd0);
        tick();
        check_output("swap_c3_done", 32'(bus_if.done), 32'd0);
        read_check("swap_wr_a_visible", 7'd22, 8'd28);
        tick();
        bus_if.we = 1'b0;
        check_output("swap_c4_done", 32'(bus_if.done), 32'd1);
        check_output("swap_c4_err",  32'(bus_if.err),  32'd0);
        tick();
        check_output("swap_idle_done", 32'(bus_if.done), 32'd0);
        check_output("swap_idle_busy", 32'(bus_if.busy), 32'd0);
        read_check("swap_m22", 7'd22, 8'd28);
        read_check("swap_m28", 7'd28, 8'd22);
        read_check("swap_m24", 7'd24, 8'd24);
        read_check("swap_m21", 7'd21, 8'd21);

        // COPY 21 -> 25
        apply_stimulus(1'b1, 2'b10, 7'd21, 7'd25);
        tick();
        apply_stimulus(1'b0, 2'b00, 7'd0, 7'd0);
`ifdef SWAP_COPY_EN
        check_output("copy_c1_done", 32'(bus_if.done), 32'd0);
        tick();
        check_output("copy_c2_done", 32'(bus_if.done), 32'd0);
        tick();
        check_output("copy_c3_done", 32'(bus_if.done), 32'd1);
        tick();
        read_check("copy_m25", 7'd25, 8'd21);
        read_check("copy_m21", 7'd21, 8'd21);
`else
        check_output("copy_err",  32'(bus_if.err),  32'd1);
        check_output("copy_done", 32'(bus_if.done), 32'd0);
        tick();
        check_output("copy_err_end", 32'(bus_if.err), 32'd0);
        read_check("copy_m25", 7'd25, 8'd25);
`endif

        // Out-of-range operand
        apply_stimulus(1'b1, 2'b01, 7'd22, 7'd120);
        tick();
        apply_stimulus(1'b0, 2'b00, 7'd0, 7'd0);
        check_output("oor_err",  32'(bus_if.err),  32'd1);
        check_output("oor_done", 32'(bus_if.done), 32'd0);
        check_output("oor_busy", 32'(bus_if.busy), 32'd1);
        tick();
        check_output("oor_err_end",  32'(bus_if.err),       32'd0);
        check_output("oor_ready",    32'(bus_if.cmd_ready), 32'd1);
        read_check("oor_m22", 7'd22, 8'd28);

        // Reserved op
        apply_stimulus(1'b1, 2'b11, 7'd22, 7'd28);
        tick();
        apply_stimulus(1'b0, 2'b00, 7'd0, 7'd0);
        check_output("rsvd_err",  32'(bus_if.err),  32'd1);
        check_output("rsvd_done", 32'(bus_if.done), 32'd0);
        tick();
        read_check("rsvd_m22", 7'd22, 8'd28);
        read_check("rsvd_m28", 7'd28, 8'd22);

        // NOP completes one cycle after acceptance
        apply_stimulus(1'b1, 2'b00, 7'd1, 7'd2);
        tick();
        apply_stimulus(1'b0, 2'b00, 7'd0, 7'd0);
        check_output("nop_done", 32'(bus_if.done), 32'd1);
        check_output("nop_err",  32'(bus_if.err),  32'd0);
        tick();

        // Same-address SWAP: normal timing, memory unchanged
        apply_stimulus(1'b1, 2'b01, 7'd23, 7'd23);
        tick();
        apply_stimulus(1'b0, 2'b00, 7'd0, 7'd0);
        tick();
        tick();
        check_output("same_c3_done", 32'(bus_if.done), 32'd0);
        tick();
        check_output("same_c4_done", 32'(bus_if.done), 32'd1);
        tick();
        read_check("same_m23", 7'd23, 8'd23);

        // Host write and command accepted on the same edge
        bus_if.we = 1'b1;
        bus_if.addr_w = 7'd26;
        bus_if.data_w = 8'h5A;
        apply_stimulus(1'b1, 2'b01, 7'd26, 7'd27);
        tick();
        bus_if.we = 1'b0;
        apply_stimulus(1'b0, 2'b00, 7'd0, 7'd0);
        tick();
        tick();
        tick();
        check_output("wrcmd_done", 32'(bus_if.done), 32'd1);
        tick();
        read_check("wrcmd_m26", 7'd26, 8'd27);
        read_check("wrcmd_m27", 7'd27, 8'h5A);

        // Reset while in WR_B of a SWAP
        apply_stimulus(1'b1, 2'b01, 7'd20, 7'd29);
        tick();
        apply_stimulus(1'b0, 2'b00, 7'd0, 7'd0);
        tick();
        tick();
        check_output("abort_pre_busy", 32'(bus_if.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check_output("abort_busy", 32'(bus_if.busy), 32'd0);
        check_output("abort_done", 32'(bus_if.done), 32'd0);
        read_check("abort_m20", 7'd20, 8'd0);
        read_check("abort_m29", 7'd29, 8'd0);
        read_check("abort_m99", 7'd99, 8'd0);
        tick();
        reset_n = 1'b1;
        #1;
        check_output("abort_ready", 32'(bus_if.cmd_ready), 32'd1);
        tick();
        check_output("abort_ready_later", 32'(bus_if.cmd_ready), 32'd1);
        read_check("abort_m22", 7'd22, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
